pong_render: RTL and testbench

Pixel-stage renderer directly downstream of the `vga_gen` timing generator. Consumes its raster counters (`x`, `y`) and syncs, and runs a single-player pong game: one paddle, one ball, three walls, with state updated once per frame. Emits registered 1-bit-per-channel RGB, plus syncs delayed to stay pixel-aligned with the RGB, to the VGA pins.

---
 rtl/pong_pkg.sv | 43 ++++
 rtl/pong_if.sv | 29 ++
 rtl/pong_physics.sv | 135 +++++++++++++
 rtl/pong_render.sv | 71 +++++++
 tb/tb_pong_render.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong renderer and its physics core.
// coord_t is the raster coordinate type shared with the vga_gen timing generator.
package pong_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        MISS = 2'd2
    } pong_state_t;

    localparam coord_t H_VIS     = 10'd480;
    localparam coord_t V_VIS     = 10'd480;
    localparam coord_t WALL      = 10'd4;
    localparam coord_t PAD_X     = 10'd16;
    localparam coord_t PAD_W     = 10'd8;
    localparam coord_t PAD_H     = 10'd64;
    localparam coord_t BALL_SZ   = 10'd8;
    localparam coord_t BALL_STEP = 10'd2;
    localparam coord_t PAD_STEP  = 10'd4;
    localparam int     MISS_FRAMES = 30;

    localparam coord_t PAD_MAX  = V_VIS - WALL - PAD_H;
    localparam coord_t PAD_RST  = (V_VIS - PAD_H) / 2;
    localparam coord_t PARK_X   = PAD_X + PAD_W;
    localparam coord_t PARK_OFS = PAD_H / 2 - BALL_SZ / 2;
    localparam logic [4:0] MISS_LOAD = 5'(MISS_FRAMES - 1);

    // {r,g,b}
    localparam logic [2:0] RGB_BLANK = 3'b000;
    localparam logic [2:0] RGB_BALL  = 3'b110;
    localparam logic [2:0] RGB_PAD   = 3'b111;
    localparam logic [2:0] RGB_SCORE = 3'b010;
    localparam logic [2:0] RGB_WALL  = 3'b001;
    localparam logic [2:0] RGB_MISS  = 3'b100;

    // v in [lo, lo+len), evaluated 11 bits wide so lo+len cannot wrap
    function automatic logic in_span(coord_t v, coord_t lo, coord_t len);
        return (v >= lo) && (11'(v) < 11'(lo) + 11'(len));
    endfunction

endpackage

// File: rtl/pong_if.sv
// Raster/button inputs from the timing generator and board, VGA pin outputs.
interface pong_if;
    import pong_pkg::*;

    coord_t x_in;
    coord_t y_in;
    logic   h_sync_in;
    logic   v_sync_in;
    logic   btn_up;
    logic   btn_dn;
    logic   serve;
    logic   h_sync;
    logic   v_sync;
    logic   r;
    logic   g;
    logic   b;
    logic   playing;

    modport master (
        output x_in, y_in, h_sync_in, v_sync_in, btn_up, btn_dn, serve,
        input  h_sync, v_sync, r, g, b, playing
    );

    modport slave (
        input  x_in, y_in, h_sync_in, v_sync_in, btn_up, btn_dn, serve,
        output h_sync, v_sync, r, g, b, playing
    );

endinterface

// File: rtl/pong_physics.sv
// Once-per-frame game update: paddle, ball, IDLE/PLAY/MISS FSM.
// PONG_SCORE_EN adds a saturating 4-bit miss counter (o_misses stays 0 otherwise).
module pong_physics
    import pong_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tick,
    input  logic        i_btn_up,
    input  logic        i_btn_dn,
    input  logic        i_serve,
    output coord_t      o_ball_x,
    output coord_t      o_ball_y,
    output coord_t      o_pad_y,
    output pong_state_t o_state,
    output logic        o_playing,
    output logic [3:0]  o_misses
);

    pong_state_t r_state, w_state_nxt;
    coord_t      r_ball_x, r_ball_y, r_pad_y, w_pad_nxt;
    logic        r_dx_neg, r_dy_neg, w_dx_neg_nxt, w_dy_neg_nxt;
    logic        r_serve_pend, r_playing;
    logic [4:0]  r_miss_cnt;
    logic        w_miss, w_pad_hit, w_park, w_step, w_miss_entry;

    // Bounce/miss decisions use the pre-step position so the step never underflows
    always_comb begin
        w_dy_neg_nxt = r_dy_neg;
        if (r_dy_neg && r_ball_y <= WALL + BALL_STEP)
            w_dy_neg_nxt = 1'b0;
        else if (!r_dy_neg && r_ball_y + BALL_SZ >= V_VIS - WALL - BALL_STEP)
            w_dy_neg_nxt = 1'b1;

        w_pad_hit    = (r_ball_y + BALL_SZ > r_pad_y) && (r_ball_y < r_pad_y + PAD_H);
        w_dx_neg_nxt = r_dx_neg;
        w_miss       = 1'b0;
        if (!r_dx_neg && r_ball_x + BALL_SZ >= H_VIS - WALL - BALL_STEP)
            w_dx_neg_nxt = 1'b1;
        else if (r_dx_neg && r_ball_x <= PAD_X + PAD_W) begin
            if (w_pad_hit)
                w_dx_neg_nxt = 1'b0;
            else if (r_ball_x <= BALL_STEP)
                w_miss = 1'b1;
        end
    end

    always_comb begin
        w_pad_nxt = r_pad_y;
        if (i_btn_up && !i_btn_dn)
            w_pad_nxt = (r_pad_y < WALL + PAD_STEP) ? WALL : r_pad_y - PAD_STEP;
        else if (i_btn_dn && !i_btn_up)
            w_pad_nxt = (r_pad_y + PAD_STEP > PAD_MAX) ? PAD_MAX : r_pad_y + PAD_STEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      r_state <= IDLE;
        else if (i_tick) r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_serve_pend)      w_state_nxt = PLAY;
            PLAY:    if (w_miss)            w_state_nxt = MISS;
            MISS:    if (r_miss_cnt == '0)  w_state_nxt = IDLE;
            default:                        w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_park       = (r_state == IDLE);
        w_step       = (r_state == PLAY) && !w_miss;
        w_miss_entry = (r_state == PLAY) && w_miss;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pad_y      <= PAD_RST;
            r_ball_x     <= PARK_X;
            r_ball_y     <= PAD_RST + PARK_OFS;
            r_dx_neg     <= 1'b0;
            r_dy_neg     <= 1'b0;
            r_serve_pend <= 1'b0;
            r_miss_cnt   <= '0;
            r_playing    <= 1'b0;
        end else begin
            // any state change (IDLE->PLAY, PLAY->MISS) consumes the pending serve
            if (i_tick && w_state_nxt != r_state)
                r_serve_pend <= 1'b0;
            else if (i_serve && r_state == IDLE)
                r_serve_pend <= 1'b1;

            if (i_tick) begin
                r_pad_y   <= w_pad_nxt;
                r_playing <= (w_state_nxt == PLAY);
                if (w_park) begin
                    r_ball_x <= PARK_X;
                    r_ball_y <= r_pad_y + PARK_OFS;
                    r_dx_neg <= 1'b0;
                    r_dy_neg <= 1'b0;
                end else if (w_step) begin
                    r_dx_neg <= w_dx_neg_nxt;
                    r_dy_neg <= w_dy_neg_nxt;
                    r_ball_x <= w_dx_neg_nxt ? r_ball_x - BALL_STEP : r_ball_x + BALL_STEP;
                    r_ball_y <= w_dy_neg_nxt ? r_ball_y - BALL_STEP : r_ball_y + BALL_STEP;
                end
                if (w_miss_entry)
                    r_miss_cnt <= MISS_LOAD;
                else if (r_state == MISS && r_miss_cnt != '0)
                    r_miss_cnt <= r_miss_cnt - 5'd1;
            end
        end
    end

`ifdef PONG_SCORE_EN
    logic [3:0] r_misses;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_misses <= '0;
        else if (i_tick && w_miss_entry && r_misses != 4'hF)
            r_misses <= r_misses + 4'd1;
    end
    assign o_misses = r_misses;
`else
    assign o_misses = 4'd0;
`endif

    assign o_ball_x  = r_ball_x;
    assign o_ball_y  = r_ball_y;
    assign o_pad_y   = r_pad_y;
    assign o_state   = r_state;
    assign o_playing = r_playing;

endmodule

// File: rtl/pong_render.sv
// Pong pixel stage: frame tick detect, object compare, colour priority, output regs.
// With PONG_SCORE_EN the miss count is drawn as a green bar in the top wall.
module pong_render
    import pong_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    pong_if.slave vif
);

    coord_t      w_ball_x, w_ball_y, w_pad_y;
    pong_state_t w_state;
    logic        w_playing, w_tick;
    logic [3:0]  w_misses;
    logic        w_vis, w_ball, w_pad, w_wall, w_score;
    logic [2:0]  w_rgb, r_rgb;
    logic        r_h_sync, r_v_sync;

    assign w_tick = (vif.x_in == '0) && (vif.y_in == V_VIS);

    pong_physics u_physics (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_tick    (w_tick),
        .i_btn_up  (vif.btn_up),
        .i_btn_dn  (vif.btn_dn),
        .i_serve   (vif.serve),
        .o_ball_x  (w_ball_x),
        .o_ball_y  (w_ball_y),
        .o_pad_y   (w_pad_y),
        .o_state   (w_state),
        .o_playing (w_playing),
        .o_misses  (w_misses)
    );

    always_comb begin
        w_vis   = (vif.x_in < H_VIS) && (vif.y_in < V_VIS);
        w_ball  = in_span(vif.x_in, w_ball_x, BALL_SZ) && in_span(vif.y_in, w_ball_y, BALL_SZ);
        w_pad   = in_span(vif.x_in, PAD_X, PAD_W) && in_span(vif.y_in, w_pad_y, PAD_H);
        w_wall  = (vif.y_in < WALL) || (vif.y_in >= V_VIS - WALL) || (vif.x_in >= H_VIS - WALL);
        // 16 px per miss; w_misses is tied to 0 when scoring is compiled out
        w_score = (vif.y_in < WALL) && (vif.x_in < {2'b00, w_misses, 4'b0000});

        if (!w_vis)       w_rgb = RGB_BLANK;
        else if (w_ball)  w_rgb = RGB_BALL;
        else if (w_pad)   w_rgb = RGB_PAD;
        else if (w_score) w_rgb = RGB_SCORE;
        else if (w_wall)  w_rgb = RGB_WALL;
        else              w_rgb = (w_state == MISS) ? RGB_MISS : RGB_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb    <= RGB_BLANK;
            r_h_sync <= 1'b1;
            r_v_sync <= 1'b1;
        end else begin
            r_rgb    <= w_rgb;
            r_h_sync <= vif.h_sync_in;
            r_v_sync <= vif.v_sync_in;
        end
    end

    assign vif.r       = r_rgb[2];
    assign vif.g       = r_rgb[1];
    assign vif.b       = r_rgb[0];
    assign vif.h_sync  = r_h_sync;
    assign vif.v_sync  = r_v_sync;
    assign vif.playing = w_playing;

endmodule

// File: tb/tb_pong_render.sv
// Randomized bench for pong_render: raster positions are driven directly so each
// "frame" is one tick cycle plus a few probe pixels, checked against a game model.
module tb_pong_render;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pong_if vif();

    pong_render dut (
        .clk   (clk),
        .rst_n (rst_n),
        .vif   (vif.slave)
    );

    int total = 0;
    int bad   = 0;

    // game model: state 0=idle 1=play 2=miss, directions as +1/-1
    int m_st, m_bx, m_by, m_dx, m_dy, m_pad, m_cnt, m_misses;
    bit m_pend;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_pad = 208; m_bx = 24; m_by = 236;
        m_dx = 1; m_dy = 1; m_pend = 0; m_cnt = 0; m_misses = 0;
    endtask

    function automatic int exp_rgb(int x, int y);
        if (x >= 480 || y >= 480) return 0;
        if (x >= m_bx && x < m_bx + 8 && y >= m_by && y < m_by + 8) return 6;
        if (x >= 16 && x < 24 && y >= m_pad && y < m_pad + 64) return 7;
`ifdef PONG_SCORE_EN
        if (y < 4 && x < m_misses * 16) return 2;
`endif
        if (y < 4 || y >= 476 || x >= 476) return 1;
        return (m_st == 2) ? 4 : 0;
    endfunction

    task automatic model_tick(input bit up, input bit dn);
        int np, ndx, ndy;
        bit miss;
        np = m_pad;
        if (up && !dn) np = (m_pad - 4 < 4) ? 4 : m_pad - 4;
        if (dn && !up) np = (m_pad + 4 > 412) ? 412 : m_pad + 4;
        case (m_st)
            0: begin
                m_bx = 24; m_by = m_pad + 28; m_dx = 1; m_dy = 1;
                if (m_pend) begin m_pend = 0; m_st = 1; end
            end
            1: begin
                ndx = m_dx; ndy = m_dy; miss = 0;
                if (m_dy < 0 && m_by <= 6) ndy = 1;
                if (m_dy > 0 && m_by + 8 >= 474) ndy = -1;
                if (m_dx > 0 && m_bx + 8 >= 474) ndx = -1;
                if (m_dx < 0 && m_bx <= 24) begin
                    if (m_by + 8 > m_pad && m_by < m_pad + 64) ndx = 1;
                    else if (m_bx <= 2) miss = 1;
                end
                if (miss) begin
                    m_st = 2; m_cnt = 29;
                    if (m_misses < 15) m_misses++;
                end else begin
                    m_dx = ndx; m_dy = ndy;
                    m_bx += 2 * m_dx; m_by += 2 * m_dy;
                end
            end
            default: if (m_cnt == 0) m_st = 0; else m_cnt--;
        endcase
        m_pad = np;
    endtask

    task automatic cyc(input int x, input int y, input bit up, input bit dn, input bit sv, input string tag);
        int e;
        bit hs, vs;
        hs = 1'($urandom); vs = 1'($urandom);
        vif.x_in = 10'(x); vif.y_in = 10'(y);
        vif.h_sync_in = hs; vif.v_sync_in = vs;
        vif.btn_up = up; vif.btn_dn = dn; vif.serve = sv;
        e = exp_rgb(x, y);
        if (x == 0 && y == 480) model_tick(up, dn);
        else if (sv && m_st == 0) m_pend = 1;
        @(posedge clk); #1;
        chk({tag, "_rgb"}, {vif.r, vif.g, vif.b}, e);
        chk({tag, "_hs"}, vif.h_sync, hs);
        chk({tag, "_vs"}, vif.v_sync, vs);
        chk({tag, "_play"}, vif.playing, (m_st == 1));
    endtask

    task automatic frame(input bit up, input bit dn, input bit sv_mid, input int nprobe);
        int x, y;
        cyc(0, 480, up, dn, 0, "tick");
        for (int i = 0; i < nprobe; i++) begin
            case ($urandom % 4)
                0: begin x = $urandom_range(519); y = $urandom_range(499); end
                1: begin x = m_bx - 1 + $urandom_range(9); y = m_by - 1 + $urandom_range(9); end
                2: begin x = 15 + $urandom_range(9); y = m_pad - 1 + $urandom_range(65); end
                default: begin x = $urandom_range(260); y = $urandom_range(5); end
            endcase
            if (x == 0 && y == 480) x = 1;
            cyc(x, y, up, dn, sv_mid && (i == nprobe / 2), "px");
        end
    endtask

    bit up, dn;

    initial begin
        vif.x_in = 10'd1; vif.y_in = 10'd0;
        vif.h_sync_in = 1'b0; vif.v_sync_in = 1'b0;
        vif.btn_up = 1'b0; vif.btn_dn = 1'b0; vif.serve = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rgb", {vif.r, vif.g, vif.b}, 0);
        chk("rst_hs", vif.h_sync, 1);
        chk("rst_vs", vif.v_sync, 1);
        chk("rst_play", vif.playing, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        model_reset();

        // idle frames, fixed probes around the centred paddle
        frame(0, 0, 0, 6);
        frame(0, 0, 0, 6);
        cyc(0, 0, 0, 0, 0, "origin");
        cyc(16, 208, 0, 0, 0, "pad_top");
        cyc(23, 271, 0, 0, 0, "pad_bot");
        cyc(16, 272, 0, 0, 0, "pad_below");
        cyc(479, 200, 0, 0, 0, "rwall");
        cyc(480, 10, 0, 0, 0, "hblank");

        // serve mid-frame, play with the paddle still (wall bounces)
        frame(0, 0, 1, 6);
        for (int f = 0; f < 300; f++) frame(0, 0, 0, 4);

        // paddle to the top wall and hold, then both buttons
        for (int f = 0; f < 60; f++) frame(1, 0, 0, 4);
        cyc(16, 4, 1, 0, 0, "pad_sat");
        cyc(16, 3, 1, 0, 0, "pad_sat_wall");
        for (int f = 0; f < 5; f++) frame(1, 1, 0, 4);

        up = 0; dn = 0;
        for (int f = 0; f < 2500; f++) begin
            if ($urandom % 8 == 0) begin up = 1'($urandom); dn = 1'($urandom); end
            frame(up, dn, ($urandom % 16) == 0, 4);
        end

        // asynchronous reset in the middle of a line while playing
        for (int k = 0; k < 600 && m_st != 1; k++) frame(0, 0, 1, 4);
        chk("reach_play", vif.playing, 1);
        cyc(m_bx, m_by, 0, 0, 0, "pre_rst");
        vif.h_sync_in = 1'b0; vif.v_sync_in = 1'b0;
        vif.x_in = 10'(m_bx); vif.y_in = 10'(m_by);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_rgb", {vif.r, vif.g, vif.b}, 0);
        chk("mid_rst_hs", vif.h_sync, 1);
        chk("mid_rst_vs", vif.v_sync, 1);
        chk("mid_rst_play", vif.playing, 0);
        @(negedge clk) rst_n = 1'b1;
        model_reset();

        for (int f = 0; f < 800; f++) begin
            if ($urandom % 8 == 0) begin up = 1'($urandom); dn = 1'($urandom); end
            frame(up, dn, ($urandom % 16) == 0, 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
